ast_responder: RTL and testbench

Responder at the root of the access scheduler tree. It accepts the winning request from the tree (payload plus the index of the serviced requester), queues it, executes it against a local 64-bit-word memory, and returns the response only to the requester that issued it. It is the far end of the request path: the tree chooses who is served, and this block serves them and routes the answer back.

---
 rtl/ast_pkg.sv | 20 ++
 rtl/ast_req_fifo.sv | 55 +++++
 rtl/ast_responder.sv | 125 ++++++++++++
 tb/tb_ast_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ast_pkg.sv
// Shared definitions for the access-scheduler-tree responder.
// - OP_READ / OP_WRITE opcodes
// - bit positions of the 132-bit request payload
// - execution FSM states
package ast_pkg;

  localparam logic [3:0] OP_READ  = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;

  // Payload layout: [131:128] opcode, [127:64] address, [63:0] write data
  localparam int OPC_HI   = 131;
  localparam int OPC_LO   = 128;
  localparam int ADDR_HI  = 127;
  localparam int ADDR_LO  = 64;
  localparam int WDATA_HI = 63;
  localparam int WDATA_LO = 0;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

endpackage

// File: rtl/ast_req_fifo.sv
// Synchronous request queue with synchronous active-high reset.
// Ports:
//   clk, rst          clock / sync reset (empties the queue)
//   push, push_data   write side; ignored when full
//   pop, pop_data     read side; pop_data shows the head, pop ignored when empty
//   full, empty       status, both derived from the registered count
//   count             occupancy, log2(depth)+1 bits
module ast_req_fifo #(
  parameter int width = 135,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [width-1:0]         push_data,
  input  logic                     pop,
  output logic [width-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int aw = $clog2(depth);

  logic [width-1:0] store [depth];
  logic [aw-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // No bypass: a full queue refuses a push even if it pops on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full     = (count == (aw+1)'(depth));
  assign empty    = (count == '0);
  assign pop_data = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // depth is a power of two, so pointers wrap naturally
      if (do_push) wr_ptr <= wr_ptr + aw'(1);
      if (do_pop)  rd_ptr <= rd_ptr + aw'(1);
      count <= count + (aw+1)'(do_push) - (aw+1)'(do_pop);
    end
  end

  // Storage needs no reset; stale entries are never visible past the pointers.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ast_responder.sv
// Root responder of the access scheduler tree. Queues winning requests,
// executes them against a local 64-bit memory and routes each response back
// to the requester that issued it.
// Ports:
//   clk, rst                       clock / sync active-high reset
//   in_valid, in_ready             request handshake (in_ready = queue not full)
//   in_src                         serviced requester index
//   in_data                        {opcode[3:0], addr[63:0], wdata[63:0]}
//   resp_valid[N], resp_ready[N]   one-hot response handshake per requester
//   resp_data, resp_err            registered response payload
//   busy                           queue non-empty or FSM not idle
module ast_responder
  import ast_pkg::*;
#(
  parameter int switch_bits   = 3,
  parameter int data_width    = 132,
  parameter int mem_addr_bits = 6,
  parameter int fifo_depth    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [switch_bits-1:0]        in_src,
  input  logic [data_width-1:0]         in_data,
  output logic [(1<<switch_bits)-1:0]   resp_valid,
  input  logic [(1<<switch_bits)-1:0]   resp_ready,
  output logic [63:0]                   resp_data,
  output logic                          resp_err,
  output logic                          busy
);

  localparam int fw    = switch_bits + data_width;
  localparam int words = 1 << mem_addr_bits;

  state_t                     state, state_n;
  logic                       pop, full, empty;
  logic [$clog2(fifo_depth):0] count;
  logic [fw-1:0]              head;

  // Execution registers: the request currently in EXEC/RESP
  logic [switch_bits-1:0]     src_q;
  logic [3:0]                 opc_q;
  logic [63:0]                addr_q, wdata_q;

  logic [63:0]                mem [words];
  logic                       addr_bad, is_read, is_write;
  logic [mem_addr_bits-1:0]   idx;

  ast_req_fifo #(.width(fw), .depth(fifo_depth)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data ({in_src, in_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign in_ready = !full;
  assign busy     = (count != '0) || (state != IDLE);

  // Any address bit above the memory range makes the request an error.
  assign addr_bad = |addr_q[63:mem_addr_bits];
  assign idx      = addr_q[mem_addr_bits-1:0];
  assign is_read  = !addr_bad && (opc_q == OP_READ);
  assign is_write = !addr_bad && (opc_q == OP_WRITE);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_n = EXEC;
      end
      EXEC: state_n = RESP;
      RESP: if (resp_ready[src_q]) begin
        // Chain straight into the next request to sustain 2 cycles/response
        if (!empty) begin
          pop     = 1'b1;
          state_n = EXEC;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    resp_valid = '0;
    if (state == RESP) resp_valid[src_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset wins over an in-flight WRITE, so it is never committed.
      state     <= IDLE;
      src_q     <= '0;
      opc_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      for (int i = 0; i < words; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      if (pop) begin
        src_q   <= head[fw-1 -: switch_bits];
        opc_q   <= head[OPC_HI:OPC_LO];
        addr_q  <= head[ADDR_HI:ADDR_LO];
        wdata_q <= head[WDATA_HI:WDATA_LO];
      end
      if (state == EXEC) begin
        resp_err  <= !(is_read || is_write);
        resp_data <= is_read ? mem[idx] : 64'h0;
        if (is_write) mem[idx] <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_ast_responder.sv
// Self-checking bench for ast_responder: directed steps followed by random
// traffic, compared against a queue-based transaction model.
module tb_ast_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_src;
  logic [131:0] in_data;
  logic [7:0]   resp_valid;
  logic [7:0]   resp_ready;
  logic [63:0]  resp_data;
  logic         resp_err;
  logic         busy;

  always #5 clk = ~clk;

  ast_responder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_src     (in_src),
    .in_data    (in_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  typedef struct {
    logic [2:0]  src;
    logic [63:0] data;
    logic        err;
  } exp_t;

  // Model: memory contents in acceptance order plus the expected responses.
  logic [63:0] mm [64];
  exp_t        expq [$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        hs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] src, input logic [131:0] d);
    exp_t        e;
    logic [3:0]  opc;
    logic [63:0] a;
    opc    = d[131:128];
    a      = d[127:64];
    e.src  = src;
    e.data = 64'h0;
    e.err  = 1'b0;
    if (a >= 64 || opc > 4'h1) e.err = 1'b1;
    else if (opc == 4'h0) e.data = mm[a[5:0]];
    else mm[a[5:0]] = d[63:0];
    return e;
  endfunction

  // One clock: check the response on offer, track the model, advance to the
  // next falling edge (inputs change and outputs are sampled there).
  task automatic tick();
    exp_t e;
    hs = 1'b0;
    if (!rst) begin
      if (resp_valid !== 8'h0) begin
        if (expq.size() == 0) begin
          chk("spurious_resp", {56'h0, resp_valid}, 64'h0);
        end else begin
          e = expq[0];
          chk("resp_route", {56'h0, resp_valid}, {56'h0, 8'h1 << e.src});
          chk("resp_data", resp_data, e.data);
          chk("resp_err", {63'h0, resp_err}, {63'h0, e.err});
          if (resp_ready[e.src]) begin
            void'(expq.pop_front());
            hs = 1'b1;
          end
        end
      end
      if (in_valid && in_ready) expq.push_back(model(in_src, in_data));
    end
    @(posedge clk);
    if (rst) begin
      expq.delete();
      for (int i = 0; i < 64; i++) mm[i] = 64'h0;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [2:0] src, input logic [3:0] opc,
                      input logic [63:0] addr, input logic [63:0] wd);
    in_valid = 1'b1;
    in_src   = src;
    in_data  = {opc, addr, wd};
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    in_valid   = 1'b0;
    resp_ready = 8'hFF;
    k = 0;
    while ((expq.size() != 0 || busy) && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_left"}, 64'(expq.size()), 64'h0);
    chk({tag, "_busy"}, {63'h0, busy}, 64'h0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {63'h0, in_ready}, 64'h1);
    chk({tag, "_resp_valid"}, {56'h0, resp_valid}, 64'h0);
    chk({tag, "_resp_data"}, resp_data, 64'h0);
    chk({tag, "_resp_err"}, {63'h0, resp_err}, 64'h0);
    chk({tag, "_busy"}, {63'h0, busy}, 64'h0);
  endtask

  initial begin
    logic [9:0] pat;
    int         k;
    rst = 1'b1; in_valid = 1'b0; in_src = '0; in_data = '0; resp_ready = 8'hFF;
    @(negedge clk);

    // Reset state
    tick(); tick();
    chk_reset_vals("reset");
    rst = 1'b0;

    // WRITE then READ, with latency check
    send(3'd2, 4'h1, 64'd5, 64'hDEADBEEF_CAFEF00D);
    chk("lat_e0_valid", {56'h0, resp_valid}, 64'h0);
    chk("lat_e0_busy", {63'h0, busy}, 64'h1);
    tick();
    chk("lat_e1_valid", {56'h0, resp_valid}, 64'h0);
    tick();
    chk("lat_e2_valid", {56'h0, resp_valid}, 64'h04);
    drain("wr");
    send(3'd7, 4'h0, 64'd5, 64'h0);
    tick(); tick();
    chk("rd_valid", {56'h0, resp_valid}, 64'h80);
    chk("rd_data", resp_data, 64'hDEADBEEF_CAFEF00D);
    drain("rd");

    // Error cases; a bad-address write must not alias onto word 0
    send(3'd1, 4'h3, 64'd5, 64'h1111);
    send(3'd3, 4'h0, 64'h40, 64'h0);
    send(3'd4, 4'h1, 64'h40, 64'h5555_AAAA);
    send(3'd5, 4'h0, 64'd0, 64'h0);
    send(3'd6, 4'h0, 64'd5, 64'h0);
    drain("err");

    // Backpressure: 5 back-to-back, queue fills
    resp_ready = 8'h00;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", {63'h0, in_ready}, 64'h1);
      in_valid = 1'b1;
      in_src   = 3'(i + 1);
      in_data  = {(i == 1) ? 4'h1 : 4'h0, 64'(i + 3), 64'(32'hA000 + i)};
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk("bp_full", {63'h0, in_ready}, 64'h0);
      in_src  = 3'd0;
      in_data = {4'h1, 64'd1, 64'hBAD};
      tick();
    end
    in_valid   = 1'b0;
    resp_ready = 8'hFF;
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      pat[i] = (resp_valid != 8'h0);
      tick();
    end
    chk("bp_cadence", {54'h0, pat}, 64'h155);
    drain("bp");

    // Non-matching ready does not advance
    resp_ready = 8'h00;
    send(3'd4, 4'h0, 64'd5, 64'h0);
    k = 0;
    while (resp_valid == 8'h0 && k < 10) begin tick(); k++; end
    resp_ready = 8'hEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nomatch_hold", {56'h0, resp_valid}, 64'h10);
    end
    resp_ready = 8'h10;
    tick();
    chk("match_adv", {56'h0, resp_valid}, 64'h0);
    drain("nm");

    // Reset with a WRITE in EXEC and 2 queued
    resp_ready = 8'h00;
    send(3'd0, 4'h0, 64'd5, 64'h0);
    send(3'd1, 4'h1, 64'd9, 64'h1234_5678);
    send(3'd2, 4'h0, 64'd9, 64'h0);
    send(3'd3, 4'h0, 64'd9, 64'h0);
    tick();
    chk("pre_rst_valid", {56'h0, resp_valid}, 64'h01);
    resp_ready = 8'h01;
    tick();
    resp_ready = 8'h00;
    rst = 1'b1;
    tick();
    chk_reset_vals("midrst");
    rst = 1'b0;
    send(3'd3, 4'h0, 64'd9, 64'h0);
    send(3'd6, 4'h0, 64'd5, 64'h0);
    drain("post_rst");

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      logic [3:0]  opc;
      logic [63:0] a;
      in_valid = ($urandom_range(0, 9) < 6);
      in_src   = 3'($urandom);
      opc      = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(2, 15))
                                              : 4'($urandom_range(0, 1));
      a        = ($urandom_range(0, 15) == 0) ? (64'h1 << $urandom_range(6, 63))
                                              : 64'($urandom_range(0, 15));
      in_data  = {opc, a, {$urandom, $urandom}};
      resp_ready = 8'($urandom);
      tick();
    end
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
